// File: rtl/noc_out_arbiter_pkg.sv
// Shared definitions for the per-direction NoC output arbiter.
// Holds the requester index map, FSM encoding and round-robin helpers.
package noc_out_arbiter_pkg;

  localparam int DW      = 32;
  localparam int NREQ    = 5;
  localparam int TIMEOUT = 15;
  localparam int IDXW    = 3;
  localparam int CNTW    = 4;
  localparam int PCW     = 16;

  // Requester order matches the Inr bit order of the OutPort stages
  localparam logic [IDXW-1:0] P_W = 3'd0;
  localparam logic [IDXW-1:0] P_S = 3'd1;
  localparam logic [IDXW-1:0] P_E = 3'd2;
  localparam logic [IDXW-1:0] P_N = 3'd3;
  localparam logic [IDXW-1:0] P_L = 3'd4;

  localparam logic [CNTW-1:0] TMR_LOAD = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic logic [IDXW-1:0] rr_next(input logic [IDXW-1:0] idx);
    return (idx >= P_L) ? '0 : idx + 3'd1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/noc_out_arbiter_if.sv
// Request/grant and downstream-link bundle of one output arbiter.
// master = requester side plus downstream FIFO, slave = arbiter.
interface noc_out_arbiter_if;
  import noc_out_arbiter_pkg::*;

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] data_in;
  logic               link_full;
  logic [NREQ-1:0]    gnt;
  logic               link_wrreq;
  logic [DW-1:0]      link_data;
  logic [PCW-1:0]     pkt_cnt;
  logic               err;

  modport master (
    output req, data_in, link_full,
    input  gnt, link_wrreq, link_data, pkt_cnt, err
  );

  modport slave (
    input  req, data_in, link_full,
    output gnt, link_wrreq, link_data, pkt_cnt, err
  );

endinterface

// File: rtl/noc_out_arbiter_rr_pick5.sv
// Combinational round-robin pick: first set request after i_rr_last,
// wrapping modulo NREQ, so the last winner has the lowest priority.
module noc_out_arbiter_rr_pick5
  import noc_out_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [IDXW-1:0] i_rr_last,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  logic [IDXW-1:0] w_cand;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = rr_next(i_rr_last);
    for (int k = 0; k < NREQ; k++) begin
      if (!o_any && i_req[w_cand]) begin
        o_idx = w_cand;
        o_any = 1'b1;
      end
      w_cand = rr_next(w_cand);
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Per-direction output arbiter: round-robin grant, one registered write
// to the downstream FIFO, then wait for the winner to release its request.
//
// state | meaning
// IDLE  | waiting for a request while the link is not full
// SEND  | flit latched; write strobe and grant driven for one cycle
// WAIT  | waiting for the winner to drop req, bounded by the timeout
module noc_out_arbiter
  import noc_out_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  noc_out_arbiter_if.slave bus
);

  state_e          r_state, w_state_nxt;
  logic [IDXW-1:0] r_win, r_rr_last;
  logic [DW-1:0]   r_link_data;
  logic [NREQ-1:0] r_gnt, w_gnt_nxt;
  logic            r_wrreq, w_wrreq_nxt;
  logic [PCW-1:0]  r_pkt_cnt;
  logic            r_err;
  logic [CNTW-1:0] r_tmr;
  logic [IDXW-1:0] w_pick_idx;
  logic            w_pick_any;
  logic [DW-1:0]   w_data_sel;
  logic            w_start, w_released, w_tmo;

  noc_out_arbiter_rr_pick5 u_pick (
    .i_req     (bus.req),
    .i_rr_last (r_rr_last),
    .o_idx     (w_pick_idx),
    .o_any     (w_pick_any)
  );

  always_comb begin
    w_data_sel = '0;
    for (int i = 0; i < NREQ; i++)
      if (w_pick_idx == IDXW'(i)) w_data_sel = bus.data_in[i*DW +: DW];
  end

  // link_full only gates the decision in IDLE; a write already in SEND completes
  assign w_start    = (r_state == ST_IDLE) && w_pick_any && !bus.link_full;
  assign w_released = !bus.req[r_win];
  assign w_tmo      = (r_tmr == '0);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_SEND;
      ST_SEND: w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_released || w_tmo) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt   = '0;
    w_wrreq_nxt = 1'b0;
    if (w_start) begin
      w_gnt_nxt   = onehot(w_pick_idx);
      w_wrreq_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gnt       <= '0;
      r_wrreq     <= 1'b0;
      r_link_data <= '0;
      r_win       <= '0;
      r_rr_last   <= P_L;
      r_tmr       <= '0;
      r_err       <= 1'b0;
    end else begin
      r_gnt   <= w_gnt_nxt;
      r_wrreq <= w_wrreq_nxt;
      if (w_start) begin
        r_link_data <= w_data_sel;
        r_win       <= w_pick_idx;
        r_rr_last   <= w_pick_idx;
      end
      if (r_state == ST_SEND)
        r_tmr <= TMR_LOAD;
      else if (r_state == ST_WAIT && !w_tmo)
        r_tmr <= r_tmr - 1'b1;
      if (r_state == ST_WAIT && !w_released && w_tmo)
        r_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                 r_pkt_cnt <= '0;
    else if (r_state == ST_SEND) r_pkt_cnt <= r_pkt_cnt + 1'b1;
  end

  assign bus.gnt        = r_gnt;
  assign bus.link_wrreq = r_wrreq;
  assign bus.link_data  = r_link_data;
  assign bus.pkt_cnt    = r_pkt_cnt;
  assign bus.err        = r_err;

endmodule
